// File: rtl/mux4_sched_pkg.sv
// Shared types and helpers for the four-requester round-robin mux scheduler:
// FSM state encoding, the rotating-priority winner search and a one-hot decoder.
package mux4_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_GRANT  = 2'b01,
        ST_SWITCH = 2'b10
    } state_t;

    // First requester found scanning ptr, ptr+1, ... modulo 4; returns ptr when nobody requests.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] ptr);
        logic [1:0] idx;
        logic [1:0] win;
        logic       found;
        win   = ptr;
        found = 1'b0;
        for (int i = 0; i < 4; i++) begin
            idx = ptr + 2'(i);
            if (!found && req[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_sel.sv
// Shared 4:1 one-bit data mux; the output is forced low while no requester owns it.
module mux4_sel (
    input  logic [3:0] data,
    input  logic [1:0] sel,
    input  logic       en,
    output logic       y
);

    assign y = en & data[sel];

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin, time-sliced owner of a shared 4:1 mux with a one-cycle gap between owners.
// Optional MUX4_SCHED_LOCK_EN adds a lock input that holds off slice expiry.
module mux4_rr_sched
    import mux4_sched_pkg::*;
#(
    parameter int SLICE = 16,  // legal 2..255
    parameter int CNT_W = 8    // SLICE <= 2**CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic [3:0] data_in,
`ifdef MUX4_SCHED_LOCK_EN
    input  logic       lock,
`endif
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       valid,
    output logic       y
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICE - 1);

    state_t           state;
    state_t           next_state;
    logic [1:0]       ptr;
    logic [CNT_W-1:0] cnt;

    logic [3:0]       gnt_d;
    logic [1:0]       sel_d;
    logic             valid_d;
    logic [1:0]       ptr_d;
    logic [CNT_W-1:0] cnt_d;

    logic [1:0]       winner;
    logic             release_hit;
    logic             expire_hit;
    logic             expiry_hold;

`ifdef MUX4_SCHED_LOCK_EN
    assign expiry_hold = lock;
`else
    assign expiry_hold = 1'b0;
`endif

    // sel always names the current owner while in GRANT.
    assign winner      = rr_pick(req, ptr);
    assign release_hit = !req[sel];
    assign expire_hit  = (cnt == CNT_LAST) && (|(req & ~gnt)) && !expiry_hold;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; blocking here would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            gnt   <= 4'b0000;
            sel   <= 2'b00;
            valid <= 1'b0;
            ptr   <= 2'b00;
            cnt   <= '0;
        end else begin
            state <= next_state;
            gnt   <= gnt_d;
            sel   <= sel_d;
            valid <= valid_d;
            ptr   <= ptr_d;
            cnt   <= cnt_d;
        end
    end

    // NOTE: every combinational output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        unique case (state)
            ST_IDLE:   if (|req) next_state = ST_GRANT;
            ST_GRANT:  if (release_hit || expire_hit) next_state = ST_SWITCH;
            ST_SWITCH: next_state = (|req) ? ST_GRANT : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        gnt_d   = 4'b0000;
        sel_d   = sel;
        valid_d = 1'b0;
        ptr_d   = ptr;
        cnt_d   = cnt;
        unique case (state)
            ST_GRANT: begin
                if (next_state == ST_GRANT) begin
                    gnt_d   = gnt;
                    valid_d = 1'b1;
                    if (cnt != CNT_LAST) cnt_d = cnt + 1'b1;
                end else begin
                    // Rotate priority past the departing owner.
                    ptr_d = sel + 2'd1;
                end
            end
            default: begin
                if (next_state == ST_GRANT) begin
                    sel_d   = winner;
                    gnt_d   = onehot4(winner);
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
        endcase
    end

    mux4_sel u_mux (
        .data (data_in),
        .sel  (sel),
        .en   (valid),
        .y    (y)
    );

    a_gnt_onehot0 : assert property (@(posedge clk) disable iff (rst) $onehot0(gnt));
    a_valid_gnt   : assert property (@(posedge clk) disable iff (rst) valid == (|gnt));
    a_sel_matches : assert property (@(posedge clk) disable iff (rst) valid |-> (gnt == onehot4(sel)));

endmodule
